ysyx_22041207_rd_arbiter: RTL and testbench
===========================================

YSYX_22041207_RD_ARBITER -- requirements
Module: ysyx_22041207_rd_arbiter

Interface
REQ-001 SHALL have parameter MAX_LS_STREAK, default 4: consecutive LSU grants allowed while IF waits.
REQ-002 SHALL have parameter STREAK_W, default 3: streak counter width, at least clog2(MAX_LS_STREAK+1).
REQ-003 SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-004 Ports SHALL be (name direction width meaning):
clk  in  1  clock
rst  in  1  sync active-high reset
if_r_valid  in  1  IF address request
if_r_ready  out  1  IF address accepted
if_r_addr  in  64  IF fetch address
if_r_size  in  8  IF byte-lane mask
if_flush  in  1  IF redirect; discard in-flight IF read
if_data  out  64  IF read data
if_data_valid  out  1  IF data present
if_data_ready  in  1  IF consumes data
ls_r_valid  in  1  LSU address request
ls_r_ready  out  1  LSU address accepted
ls_r_addr  in  64  LSU load address
ls_r_size  in  8  LSU byte-lane mask
ls_data  out  64  LSU read data
ls_data_valid  out  1  LSU data present
ls_data_ready  in  1  LSU consumes data
m_r_valid  out  1  downstream address valid
m_r_ready  in  1  downstream address accepted
m_r_addr  out  64  downstream address
m_r_size  out  8  downstream size mask
m_data  in  64  downstream read data
m_data_valid  in  1  downstream data valid
m_data_ready  out  1  downstream data consumed

Function
REQ-005 SHALL implement FSM IDLE -> ADDR -> RESP -> IDLE; one outstanding read maximum.
REQ-006 IDLE grant rule SHALL be: grant LSU if ls_r_valid and (streak < MAX_LS_STREAK or IF not requesting); else grant IF if if_r_valid and not if_flush; else stay IDLE.
REQ-007 x_r_ready SHALL be combinational, high only in IDLE for the granted requester that cycle; the handshake completes in that cycle.
REQ-008 On grant SHALL latch addr, size and owner, and go to ADDR; m_r_valid SHALL be high from the next cycle.
REQ-009 In ADDR SHALL hold m_r_valid, m_r_addr and m_r_size stable until m_r_ready; then go to RESP with m_r_valid low the next cycle.
REQ-010 In RESP m_data_ready SHALL equal the owner's data_ready, or 1 when discard is set.
REQ-011 In RESP owner's data_valid SHALL equal m_data_valid and not discard; the non-owner's data_valid SHALL be 0; both data outputs SHALL carry m_data.
REQ-012 On m_data_valid and m_data_ready SHALL return to IDLE; the next grant SHALL be no earlier than the following cycle.
REQ-013 Streak SHALL increment (saturating) on an LSU grant while if_r_valid, clear on an IF grant, and clear on an LSU grant while IF is idle.
REQ-014 if_flush in ADDR or RESP with owner IF SHALL set discard; the read completes downstream and the data is dropped; discard clears on entering IDLE.
REQ-015 if_flush with owner LSU SHALL have no effect; if_flush in IDLE SHALL only suppress an IF grant that cycle.
REQ-016 Addresses, sizes and data SHALL pass unmodified; no width conversion.

Reset
REQ-017 rst SHALL force: state IDLE, m_r_valid 0, m_r_addr 0, m_r_size 0, streak 0, discard 0, owner IF, and all ready/valid outputs 0.
REQ-018 Reset mid-transaction SHALL abandon the read; the downstream slave shares rst.

Structure
REQ-019 Package ysyx_22041207_bus_pkg SHALL hold the FSM state enum, the owner encoding, and ADDR_W=64, SIZE_W=8, DATA_W=64.
REQ-020 Grant and streak logic SHALL be sub-module ysyx_22041207_arb_prio; the FSM and data muxing SHALL stay in the top.

Verification
REQ-021 IF-only: if_r_addr=0x80000000; slave has 2-cycle address and 3-cycle data delay, m_data=0x00000413 -> if_data_valid with if_data=0x00000413 exactly once; LSU outputs idle.
REQ-022 Simultaneous request, IF 0x80000004 and LSU 0x80001000 -> LSU served first, IF next; m_r_addr sequence 0x80001000, 0x80000004.
REQ-023 LSU held valid continuously and IF valid -> IF granted after exactly 4 LSU grants (MAX_LS_STREAK=4).
REQ-024 if_flush pulse in RESP of IF read 0x80000008 -> m_data_ready=1, if_data_valid stays 0, FSM returns to IDLE, next IF read serves normally.
REQ-025 rst asserted in ADDR with m_r_valid=1 -> next cycle all outputs 0 and state IDLE; a fresh request is then accepted normally.
REQ-026 ls_data_ready held low for 5 cycles in RESP -> m_data_ready low for those cycles, no grant issued, ls_data stable.

Source files
------------

// File: rtl/ysyx_22041207_bus_pkg.sv
// Shared encodings and widths for the single-outstanding read arbiter.
package ysyx_22041207_bus_pkg;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 8;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } rd_owner_e;

endpackage

// File: rtl/ysyx_22041207_arb_prio.sv
// Grant selection between IF and LSU with a bounded LSU streak so IF cannot starve.
module ysyx_22041207_arb_prio #(
    parameter int MAX_LS_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_r_valid,
    input  logic if_flush,
    input  logic ls_r_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    logic [STREAK_W-1:0] streak;

    // LSU wins unless it has used up its streak while IF is waiting.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (idle && !rst) begin
            if (ls_r_valid && ((streak < STREAK_MAX) || !if_r_valid)) begin
                grant_ls = 1'b1;
            end else if (if_r_valid && !if_flush) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_ls) begin
            if (!if_r_valid) begin
                streak <= '0;
            end else if (streak < STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041207_rd_arbiter.sv
// Read-channel arbiter: IF and LSU share one downstream read port, one read in flight.
// Valid/ready: a transfer happens on a cycle where both valid and ready are high at the clock edge.
module ysyx_22041207_rd_arbiter
    import ysyx_22041207_bus_pkg::*;
#(
    parameter int MAX_LS_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_r_valid,
    output logic              if_r_ready,
    input  logic [ADDR_W-1:0] if_r_addr,
    input  logic [SIZE_W-1:0] if_r_size,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_data,
    output logic              if_data_valid,
    input  logic              if_data_ready,
    input  logic              ls_r_valid,
    output logic              ls_r_ready,
    input  logic [ADDR_W-1:0] ls_r_addr,
    input  logic [SIZE_W-1:0] ls_r_size,
    output logic [DATA_W-1:0] ls_data,
    output logic              ls_data_valid,
    input  logic              ls_data_ready,
    output logic              m_r_valid,
    input  logic              m_r_ready,
    output logic [ADDR_W-1:0] m_r_addr,
    output logic [SIZE_W-1:0] m_r_size,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_data_valid,
    output logic              m_data_ready
);

    rd_state_e         state, state_d;
    rd_owner_e         owner, owner_d;
    logic              discard, discard_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              grant_if, grant_ls;
    logic              flush_hit, discard_eff;

    ysyx_22041207_arb_prio #(
        .MAX_LS_STREAK (MAX_LS_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .idle       (state == ST_IDLE),
        .if_r_valid (if_r_valid),
        .if_flush   (if_flush),
        .ls_r_valid (ls_r_valid),
        .grant_if   (grant_if),
        .grant_ls   (grant_ls)
    );

    // A flush in the same cycle as the data beat must already drop it.
    assign flush_hit   = (state != ST_IDLE) && (owner == OWNER_IF) && if_flush;
    assign discard_eff = discard || flush_hit;

    assign if_r_ready = grant_if;
    assign ls_r_ready = grant_ls;
    assign m_r_addr   = addr_q;
    assign m_r_size   = size_q;
    assign if_data    = m_data;
    assign ls_data    = m_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= OWNER_IF;
            discard <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            discard <= discard_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d       = state;
        owner_d       = owner;
        discard_d     = discard;
        addr_d        = addr_q;
        size_d        = size_q;
        m_r_valid     = 1'b0;
        m_data_ready  = 1'b0;
        if_data_valid = 1'b0;
        ls_data_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_ls) begin
                    owner_d = OWNER_LS;
                    addr_d  = ls_r_addr;
                    size_d  = ls_r_size;
                    state_d = ST_ADDR;
                end else if (grant_if) begin
                    owner_d = OWNER_IF;
                    addr_d  = if_r_addr;
                    size_d  = if_r_size;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_r_valid = 1'b1;
                if (flush_hit) discard_d = 1'b1;
                if (m_r_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                m_data_ready  = discard_eff ||
                                ((owner == OWNER_LS) ? ls_data_ready : if_data_ready);
                if_data_valid = (owner == OWNER_IF) && m_data_valid && !discard_eff;
                ls_data_valid = (owner == OWNER_LS) && m_data_valid;
                if (flush_hit) discard_d = 1'b1;
                if (m_data_valid && m_data_ready) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// Directed bench for the read arbiter: a timed downstream slave model plus per-scenario tasks.
module tb_ysyx_22041207_rd_arbiter;
    import ysyx_22041207_bus_pkg::*;

    logic        clk, rst;
    logic        if_r_valid, if_r_ready, if_flush, if_data_valid, if_data_ready;
    logic [63:0] if_r_addr, if_data;
    logic [7:0]  if_r_size;
    logic        ls_r_valid, ls_r_ready, ls_data_valid, ls_data_ready;
    logic [63:0] ls_r_addr, ls_data;
    logic [7:0]  ls_r_size;
    logic        m_r_valid, m_r_ready, m_data_valid, m_data_ready;
    logic [63:0] m_r_addr, m_data;
    logic [7:0]  m_r_size;

    int tests_run = 0;
    int tests_failed = 0;

    int          addr_delay = 0;
    int          data_delay = 0;
    logic [63:0] slave_data = '0;

    logic [63:0] addr_q[$];
    logic [63:0] exp_q[$];
    logic        grant_q[$];
    int          if_rx_cnt, ls_rx_cnt, if_dv_cnt, ls_dv_cnt, mrv_cnt;
    logic [63:0] if_rx_last, ls_rx_last;

    ysyx_22041207_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .if_r_valid(if_r_valid), .if_r_ready(if_r_ready), .if_r_addr(if_r_addr),
        .if_r_size(if_r_size), .if_flush(if_flush), .if_data(if_data),
        .if_data_valid(if_data_valid), .if_data_ready(if_data_ready),
        .ls_r_valid(ls_r_valid), .ls_r_ready(ls_r_ready), .ls_r_addr(ls_r_addr),
        .ls_r_size(ls_r_size), .ls_data(ls_data), .ls_data_valid(ls_data_valid),
        .ls_data_ready(ls_data_ready),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_addr(m_r_addr),
        .m_r_size(m_r_size), .m_data(m_data), .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- downstream slave model ----------------
    initial begin
        int   acnt, dcnt;
        logic pending, hs_a, hs_d, rst_s;
        m_r_ready = 1'b0; m_data_valid = 1'b0; m_data = '0;
        acnt = 0; dcnt = 0; pending = 1'b0;
        forever begin
            @(negedge clk);
            hs_a  = m_r_valid && m_r_ready;
            hs_d  = m_data_valid && m_data_ready;
            rst_s = rst;
            @(posedge clk); #1;
            if (rst_s) begin
                m_r_ready = 1'b0; m_data_valid = 1'b0; m_data = '0;
                acnt = 0; dcnt = 0; pending = 1'b0;
            end else begin
                if (hs_d) m_data_valid = 1'b0;
                if (hs_a) begin
                    m_r_ready = 1'b0; acnt = 0; dcnt = 0; pending = 1'b1;
                end else if (m_r_valid) begin
                    if (acnt >= addr_delay) m_r_ready = 1'b1;
                    else acnt++;
                end
                if (pending && !hs_a) begin
                    if (dcnt >= data_delay) begin
                        m_data_valid = 1'b1; m_data = slave_data; pending = 1'b0;
                    end else dcnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (if_r_valid && if_r_ready) grant_q.push_back(1'b0);
            if (ls_r_valid && ls_r_ready) grant_q.push_back(1'b1);
            if (m_r_valid && m_r_ready) addr_q.push_back(m_r_addr);
            if (m_r_valid) mrv_cnt++;
            if (if_data_valid) if_dv_cnt++;
            if (ls_data_valid) ls_dv_cnt++;
            if (if_data_valid && if_data_ready) begin if_rx_cnt++; if_rx_last = if_data; end
            if (ls_data_valid && ls_data_ready) begin ls_rx_cnt++; ls_rx_last = ls_data; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        addr_q.delete(); exp_q.delete(); grant_q.delete();
        if_rx_cnt = 0; ls_rx_cnt = 0; if_dv_cnt = 0; ls_dv_cnt = 0; mrv_cnt = 0;
        if_rx_last = '0; ls_rx_last = '0;
    endtask

    // Waits at negedges for the named ready; leaves the request asserted.
    task automatic wait_grant(input bit is_ls, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_ls ? ls_r_ready : if_r_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rx(input int want_if, input int want_ls, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_rx_cnt >= want_if && ls_rx_cnt >= want_ls) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; if_r_valid = 1'b1; ls_r_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        tests_run++; if (if_r_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_if_r_ready: got %0h exp 0", if_r_ready); end
        tests_run++; if (ls_r_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ls_r_ready: got %0h exp 0", ls_r_ready); end
        tests_run++; if (m_r_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_m_r_valid: got %0h exp 0", m_r_valid); end
        tests_run++; if (m_r_addr !== 64'h0) begin tests_failed++; $display("FAIL rst_m_r_addr: got %0h exp 0", m_r_addr); end
        tests_run++; if (m_r_size !== 8'h0) begin tests_failed++; $display("FAIL rst_m_r_size: got %0h exp 0", m_r_size); end
        tests_run++; if (m_data_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_m_data_ready: got %0h exp 0", m_data_ready); end
        tests_run++; if (if_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_data_valid: got %0h exp 0", if_data_valid); end
        tests_run++; if (ls_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_ls_data_valid: got %0h exp 0", ls_data_valid); end
        tests_run++; if (dut.state !== ST_IDLE) begin tests_failed++; $display("FAIL rst_state: got %0d exp %0d", dut.state, ST_IDLE); end
        tests_run++; if (dut.u_prio.streak !== 3'd0) begin tests_failed++; $display("FAIL rst_streak: got %0d exp 0", dut.u_prio.streak); end
        tests_run++; if (dut.owner !== OWNER_IF) begin tests_failed++; $display("FAIL rst_owner: got %0d exp %0d", dut.owner, OWNER_IF); end
        tick();
        rst = 1'b0; if_r_valid = 1'b0; ls_r_valid = 1'b0;
        tick();
    endtask

    task automatic test_if_only();
        bit ok;
        clear_mon();
        addr_delay = 2; data_delay = 3; slave_data = 64'h0000_0000_0000_0413;
        if_data_ready = 1'b1; ls_data_ready = 1'b1;
        if_r_addr = 64'h8000_0000; if_r_size = 8'hff; if_r_valid = 1'b1;
        exp_q.push_back(64'h8000_0000);
        wait_grant(1'b0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL if_only_grant: got %0h exp 1", ok); end
        tests_run++; if (ls_r_ready !== 1'b0) begin tests_failed++; $display("FAIL if_only_ls_ready: got %0h exp 0", ls_r_ready); end
        tick(); if_r_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (m_r_valid !== 1'b1) begin tests_failed++; $display("FAIL if_only_m_r_valid: got %0h exp 1", m_r_valid); end
        tests_run++; if (m_r_addr !== 64'h8000_0000) begin tests_failed++; $display("FAIL if_only_m_r_addr: got %0h exp 80000000", m_r_addr); end
        tests_run++; if (m_r_size !== 8'hff) begin tests_failed++; $display("FAIL if_only_m_r_size: got %0h exp ff", m_r_size); end
        wait_rx(1, 0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL if_only_rx_timeout: got %0h exp 1", ok); end
        repeat (8) tick();
        tests_run++; if (if_rx_cnt !== 1) begin tests_failed++; $display("FAIL if_only_rx_cnt: got %0d exp 1", if_rx_cnt); end
        tests_run++; if (if_rx_last !== 64'h413) begin tests_failed++; $display("FAIL if_only_data: got %0h exp 413", if_rx_last); end
        tests_run++; if (if_dv_cnt !== 1) begin tests_failed++; $display("FAIL if_only_dv_cycles: got %0d exp 1", if_dv_cnt); end
        tests_run++; if (ls_dv_cnt !== 0) begin tests_failed++; $display("FAIL if_only_ls_dv: got %0d exp 0", ls_dv_cnt); end
        tests_run++; if (mrv_cnt !== 3) begin tests_failed++; $display("FAIL if_only_addr_cycles: got %0d exp 3", mrv_cnt); end
        tests_run++; if (addr_q.size() !== 1) begin tests_failed++; $display("FAIL if_only_addr_count: got %0d exp 1", addr_q.size()); end
        tests_run++; if (addr_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL if_only_addr_seq: got %0h exp %0h", addr_q[0], exp_q[0]); end
    endtask

    task automatic test_simultaneous();
        bit if_g, ls_g, done;
        clear_mon();
        addr_delay = 0; data_delay = 0; slave_data = 64'h1234;
        if_r_addr = 64'h8000_0004; if_r_size = 8'hff;
        ls_r_addr = 64'h8000_1000; ls_r_size = 8'h0f;
        if_r_valid = 1'b1; ls_r_valid = 1'b1;
        exp_q.push_back(64'h8000_1000); exp_q.push_back(64'h8000_0004);
        if_g = 0; ls_g = 0; done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_r_valid && if_r_ready) if_g = 1;
            if (ls_r_valid && ls_r_ready) ls_g = 1;
            done = (if_rx_cnt >= 1) && (ls_rx_cnt >= 1);
            tick();
            if (if_g) if_r_valid = 1'b0;
            if (ls_g) ls_r_valid = 1'b0;
            if (done) break;
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL simul_timeout: got %0h exp 1", done); end
        tests_run++; if (grant_q.size() !== 2) begin tests_failed++; $display("FAIL simul_grant_count: got %0d exp 2", grant_q.size()); end
        tests_run++; if (grant_q[0] !== 1'b1) begin tests_failed++; $display("FAIL simul_first_owner: got %0h exp 1(ls)", grant_q[0]); end
        tests_run++; if (grant_q[1] !== 1'b0) begin tests_failed++; $display("FAIL simul_second_owner: got %0h exp 0(if)", grant_q[1]); end
        tests_run++; if (addr_q.size() !== 2) begin tests_failed++; $display("FAIL simul_addr_count: got %0d exp 2", addr_q.size()); end
        for (int k = 0; k < 2; k++) begin
            tests_run++; if (addr_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL simul_addr_%0d: got %0h exp %0h", k, addr_q[k], exp_q[k]); end
        end
        tests_run++; if (dut.u_prio.streak !== 3'd0) begin tests_failed++; $display("FAIL simul_streak: got %0d exp 0", dut.u_prio.streak); end
    endtask

    task automatic test_streak();
        bit if_g, done;
        clear_mon();
        addr_delay = 0; data_delay = 0; slave_data = 64'h77;
        if_r_addr = 64'h8000_0040; ls_r_addr = 64'h8000_1100;
        if_r_valid = 1'b1; ls_r_valid = 1'b1;
        if_g = 0; done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_r_valid && if_r_ready && !if_g) begin
                if_g = 1;
                tests_run++; if (dut.u_prio.streak !== 3'd4) begin tests_failed++; $display("FAIL streak_at_if_grant: got %0d exp 4", dut.u_prio.streak); end
            end
            done = if_g && (if_rx_cnt >= 1);
            tick();
            if (if_g) begin if_r_valid = 1'b0; ls_r_valid = 1'b0; end
            if (done) break;
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL streak_timeout: got %0h exp 1", done); end
        tests_run++; if (grant_q.size() !== 5) begin tests_failed++; $display("FAIL streak_grant_count: got %0d exp 5", grant_q.size()); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (grant_q[k] !== 1'b1) begin tests_failed++; $display("FAIL streak_ls_grant_%0d: got %0h exp 1", k, grant_q[k]); end
        end
        tests_run++; if (grant_q[4] !== 1'b0) begin tests_failed++; $display("FAIL streak_if_grant: got %0h exp 0", grant_q[4]); end
        tests_run++; if (dut.u_prio.streak !== 3'd0) begin tests_failed++; $display("FAIL streak_cleared: got %0d exp 0", dut.u_prio.streak); end
    endtask

    task automatic test_flush();
        bit ok;
        clear_mon();
        addr_delay = 0; data_delay = 2; slave_data = 64'hbad;
        if_data_ready = 1'b0;
        if_r_addr = 64'h8000_0008; if_r_valid = 1'b1;
        exp_q.push_back(64'h8000_0008); exp_q.push_back(64'h8000_000c);
        wait_grant(1'b0, ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL flush_grant: got %0h exp 1", ok); end
        tick(); if_r_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.state == ST_RESP) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL flush_reach_resp: got %0h exp 1", ok); end
        tick(); if_flush = 1'b1;
        @(negedge clk);
        tests_run++; if (m_data_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_m_data_ready_pulse: got %0h exp 1", m_data_ready); end
        tests_run++; if (if_data_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_if_dv_pulse: got %0h exp 0", if_data_valid); end
        tick(); if_flush = 1'b0;
        @(negedge clk);
        tests_run++; if (m_data_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_m_data_ready_held: got %0h exp 1", m_data_ready); end
        tests_run++; if (dut.discard !== 1'b1) begin tests_failed++; $display("FAIL flush_discard_set: got %0h exp 1", dut.discard); end
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dut.state == ST_IDLE) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL flush_back_idle: got %0h exp 1", ok); end
        tests_run++; if (if_dv_cnt !== 0) begin tests_failed++; $display("FAIL flush_if_dv_cycles: got %0d exp 0", if_dv_cnt); end
        tests_run++; if (dut.discard !== 1'b0) begin tests_failed++; $display("FAIL flush_discard_clear: got %0h exp 0", dut.discard); end
        tick();
        if_data_ready = 1'b1; slave_data = 64'h13;
        if_r_addr = 64'h8000_000c; if_r_valid = 1'b1;
        wait_grant(1'b0, ok);
        tick(); if_r_valid = 1'b0;
        wait_rx(1, 0, ok);
        tick();
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL flush_next_rx: got %0h exp 1", ok); end
        tests_run++; if (if_rx_last !== 64'h13) begin tests_failed++; $display("FAIL flush_next_data: got %0h exp 13", if_rx_last); end
        tests_run++; if (addr_q.size() !== 2) begin tests_failed++; $display("FAIL flush_addr_count: got %0d exp 2", addr_q.size()); end
        tests_run++; if (addr_q[1] !== exp_q[1]) begin tests_failed++; $display("FAIL flush_next_addr: got %0h exp %0h", addr_q[1], exp_q[1]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        addr_delay = 5; data_delay = 0; slave_data = 64'h99;
        ls_r_addr = 64'h8000_2000; ls_r_size = 8'hff; ls_r_valid = 1'b1;
        wait_grant(1'b1, ok);
        tick(); ls_r_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (m_r_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_in_addr: got %0h exp 1", m_r_valid); end
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        tests_run++; if (m_r_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_m_r_valid: got %0h exp 0", m_r_valid); end
        tests_run++; if (m_r_addr !== 64'h0) begin tests_failed++; $display("FAIL rmid_m_r_addr: got %0h exp 0", m_r_addr); end
        tests_run++; if (m_r_size !== 8'h0) begin tests_failed++; $display("FAIL rmid_m_r_size: got %0h exp 0", m_r_size); end
        tests_run++; if (m_data_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_m_data_ready: got %0h exp 0", m_data_ready); end
        tests_run++; if (if_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_if_dv: got %0h exp 0", if_data_valid); end
        tests_run++; if (ls_data_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_ls_dv: got %0h exp 0", ls_data_valid); end
        tests_run++; if (ls_r_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ls_ready: got %0h exp 0", ls_r_ready); end
        tests_run++; if (ls_data !== 64'h0) begin tests_failed++; $display("FAIL rmid_ls_data: got %0h exp 0", ls_data); end
        tests_run++; if (dut.state !== ST_IDLE) begin tests_failed++; $display("FAIL rmid_state: got %0d exp %0d", dut.state, ST_IDLE); end
        tests_run++; if (addr_q.size() !== 0) begin tests_failed++; $display("FAIL rmid_no_addr_hs: got %0d exp 0", addr_q.size()); end
        tick();
        addr_delay = 0; slave_data = 64'h55;
        ls_r_addr = 64'h8000_2008; ls_r_valid = 1'b1;
        exp_q.push_back(64'h8000_2008);
        wait_grant(1'b1, ok);
        tick(); ls_r_valid = 1'b0;
        wait_rx(0, 1, ok);
        tick();
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rmid_fresh_rx: got %0h exp 1", ok); end
        tests_run++; if (ls_rx_last !== 64'h55) begin tests_failed++; $display("FAIL rmid_fresh_data: got %0h exp 55", ls_rx_last); end
        tests_run++; if (addr_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL rmid_fresh_addr: got %0h exp %0h", addr_q[0], exp_q[0]); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        logic [63:0] exp_d;
        clear_mon();
        exp_d = 64'hdead_beef_cafe_f00d;
        addr_delay = 0; data_delay = 0; slave_data = exp_d;
        ls_data_ready = 1'b0;
        ls_r_addr = 64'h8000_3000; ls_r_valid = 1'b1;
        wait_grant(1'b1, ok);
        tick(); ls_r_valid = 1'b0;
        if_r_addr = 64'h8000_0010; if_r_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_data_valid) begin ok = 1; break; end
        end
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL bp_data_arrives: got %0h exp 1", ok); end
        for (int k = 0; k < 5; k++) begin
            tests_run++; if (m_data_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_m_data_ready_%0d: got %0h exp 0", k, m_data_ready); end
            tests_run++; if (if_r_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_no_grant_%0d: got %0h exp 0", k, if_r_ready); end
            tests_run++; if (ls_data !== exp_d) begin tests_failed++; $display("FAIL bp_ls_data_%0d: got %0h exp %0h", k, ls_data, exp_d); end
            tests_run++; if (ls_data_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_ls_dv_%0d: got %0h exp 1", k, ls_data_valid); end
            tick();
            @(negedge clk);
        end
        tick(); ls_data_ready = 1'b1; if_r_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (m_data_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0h exp 1", m_data_ready); end
        tick();
        @(negedge clk);
        tests_run++; if (dut.state !== ST_IDLE) begin tests_failed++; $display("FAIL bp_back_idle: got %0d exp %0d", dut.state, ST_IDLE); end
        tests_run++; if (ls_rx_cnt !== 1) begin tests_failed++; $display("FAIL bp_rx_cnt: got %0d exp 1", ls_rx_cnt); end
        tests_run++; if (ls_rx_last !== exp_d) begin tests_failed++; $display("FAIL bp_rx_data: got %0h exp %0h", ls_rx_last, exp_d); end
        tests_run++; if (grant_q.size() !== 1) begin tests_failed++; $display("FAIL bp_grant_count: got %0d exp 1", grant_q.size()); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        if_r_valid = 1'b0; if_r_addr = '0; if_r_size = '0; if_flush = 1'b0; if_data_ready = 1'b0;
        ls_r_valid = 1'b0; ls_r_addr = '0; ls_r_size = '0; ls_data_ready = 1'b0;
        clear_mon();
        test_reset();
        test_if_only();
        test_simultaneous();
        test_streak();
        test_flush();
        test_reset_mid();
        test_back_pressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
